// File: rtl/abs_pkg.sv
// Shared FSM state encoding and default alarm threshold for the abs_arbiter slice.
package abs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] THRESH_DEFAULT = 8'd100;

endpackage

// File: rtl/absoluteCalculator.sv
// Combinational two's-complement magnitude; the most negative value wraps to 2^(W-1) read as unsigned.
// Zero latency, no flow control.
module absoluteCalculator #(
  parameter int W = 8
) (
  input  logic [W-1:0] operand,
  output logic [W-1:0] magnitude
);

  assign magnitude = operand[W-1] ? (~operand + W'(1)) : operand;

endmodule

// File: rtl/abs_arbiter.sv
// Round-robin N_CH-channel sampler feeding |x| plus threshold alarm; grant to out_valid is 2 cycles, 1 sample per 3 cycles.
// Grants only in IDLE; out_ready low holds the result in HOLD while all requests wait.
module abs_arbiter
  import abs_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W = 8,
  parameter logic [W-1:0] THRESH = W'(THRESH_DEFAULT),
  localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   req_valid,
  input  logic [N_CH*W-1:0] req_data,
  output logic [N_CH-1:0]   req_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [CW-1:0]     out_ch,
  output logic              out_alarm,
  input  logic              out_ready,
  output logic              busy
);

  state_t        state, state_nxt;
  logic [CW-1:0] last_grant;
  logic [CW-1:0] pick_ch;
  logic          pick_vld;
  logic          grant;
  logic [W-1:0]  op_q;
  logic [W-1:0]  res_q;
  logic [W-1:0]  mag;
  logic [CW-1:0] ch_q;
  logic          alarm_q;

  // Walk from the farthest candidate to the nearest so the channel right after
  // last_grant is the one left standing.
  function automatic logic [CW:0] rr_pick(input logic [N_CH-1:0] vld,
                                          input logic [CW-1:0]   last);
    logic [CW:0] r;
    int          c;
    r = '0;
    for (int i = N_CH; i >= 1; i--) begin
      c = (int'(last) + i) % N_CH;
      if (vld[c]) r = {1'b1, CW'(c)};
    end
    return r;
  endfunction

  assign {pick_vld, pick_ch} = rr_pick(req_valid, last_grant);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (pick_vld && rst_n) begin
          req_ready = N_CH'(1) << pick_ch;
          state_nxt = CALC;
        end
      end
      CALC:    state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign grant = |(req_valid & req_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= CW'(N_CH - 1);
      op_q       <= '0;
      ch_q       <= '0;
      res_q      <= '0;
      alarm_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        last_grant <= pick_ch;
        op_q       <= req_data[int'(pick_ch)*W +: W];
        ch_q       <= pick_ch;
      end
      if (state == CALC) begin
        res_q   <= mag;
        alarm_q <= (mag > THRESH);
      end
    end
  end

  absoluteCalculator #(.W(W)) u_abs (
    .operand   (op_q),
    .magnitude (mag)
  );

  // Reset masks the handshake outputs immediately, before the state register clears.
  assign out_valid = rst_n && (state == HOLD);
  assign busy      = rst_n && (state != IDLE);
  assign out_data  = res_q;
  assign out_ch    = ch_q;
  assign out_alarm = alarm_q;

endmodule

// File: tb/tb_abs_arbiter.sv
// Directed bench for abs_arbiter with a scoreboard of expected results keyed to grant cycles.
module tb_abs_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_alarm;
  logic        out_ready;
  logic        busy;

  abs_arbiter #(.N_CH(4), .W(8), .THRESH(8'd100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_alarm (out_alarm),
    .out_ready (out_ready),
    .busy      (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] ch;
    logic       alarm;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   nchk  = 0;
  int   npass = 0;
  int   cyc   = 0;
  bit   seen  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] mag_of(input logic [7:0] x);
    int s;
    s = int'($signed(x));
    if (s < 0) s = -s;
    return s[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on every observed transfer, compare and pop on acceptance.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      seen = 0;
    end else begin
      if (|(req_valid & req_ready)) begin
        exp_t e;
        check("ready_onehot", 32'($countones(req_ready)), 1);
        e.ch = 0;
        for (int i = 0; i < 4; i++) if (req_ready[i]) e.ch = 2'(i);
        e.data  = mag_of(req_data[int'(e.ch)*8 +: 8]);
        e.alarm = (int'(e.data) > 100);
        e.due   = cyc + 2;
        sb.push_back(e);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 0);
        end else begin
          if (!seen) begin
            check("latency", cyc, sb[0].due);
            seen = 1;
          end
          check("sb_data", 32'(out_data), 32'(sb[0].data));
          check("sb_ch", 32'(out_ch), 32'(sb[0].ch));
          check("sb_alarm", 32'(out_alarm), 32'(sb[0].alarm));
          if (out_ready) begin
            void'(sb.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic send_one(input int ch, input logic [7:0] d,
                          input logic [7:0] exp_d, input logic exp_a);
    int n;
    req_data = '0;
    req_data[ch*8 +: 8] = d;
    req_valid = 4'(1 << ch);
    #1;
    n = 0;
    while (!req_ready[ch] && n < 10) begin
      tick();
      n++;
    end
    check("wait_grant", 32'(req_ready[ch]), 1);
    tick();
    req_valid = '0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    check("wait_out", 32'(out_valid), 1);
    check("bnd_data", 32'(out_data), 32'(exp_d));
    check("bnd_alarm", 32'(out_alarm), 32'(exp_a));
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_data  = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_ready", 32'(req_ready), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_ch", 32'(out_ch), 0);
    check("rst_alarm", 32'(out_alarm), 0);
    req_valid = '0;
    rst_n = 1'b1;
    tick();

    // Single request on ch2: -10
    req_data  = 32'h00F6_0000;
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    #1;
    check("single_busy", 32'(busy), 1);
    check("single_calc_valid", 32'(out_valid), 0);
    tick();
    check("single_valid", 32'(out_valid), 1);
    check("single_data", 32'(out_data), 10);
    check("single_ch", 32'(out_ch), 2);
    check("single_alarm", 32'(out_alarm), 0);
    tick();
    check("single_idle_valid", 32'(out_valid), 0);
    check("single_idle_busy", 32'(busy), 0);

    // Round robin from reset: all channels requesting
    do_reset();
    req_data  = 32'h4433_2211;
    req_valid = 4'hF;
    for (int k = 0; k < 12; k++) begin
      #1;
      check($sformatf("rr_k%0d", k), 32'(req_ready), (k % 3 == 0) ? (1 << (k / 3)) : 0);
      tick();
    end
    req_valid = '0;
    tick();

    // Boundary magnitudes on ch1
    send_one(1, 8'h80, 8'h80, 1'b1);
    send_one(1, 8'h7F, 8'h7F, 1'b1);
    send_one(1, 8'h00, 8'h00, 1'b0);
    send_one(1, 8'h9C, 8'd100, 1'b0);
    send_one(1, 8'h65, 8'd101, 1'b1);

    // Backpressure on a ch3 result while every channel requests
    out_ready = 1'b0;
    req_data  = 32'h0500_0033;
    req_valid = 4'b1000;
    #1;
    check("bp_grant", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    tick();
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_valid", 32'(out_valid), 1);
      check("bp_data", 32'(out_data), 5);
      check("bp_ready", 32'(req_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_idle_busy", 32'(busy), 0);
    check("bp_next_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();

    // Reset during CALC discards the in-flight result
    req_data  = 32'h0000_C800;
    req_valid = 4'b0010;
    #1;
    check("mid_grant", 32'(req_ready), 32'h2);
    tick();
    check("mid_calc_busy", 32'(busy), 1);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(out_valid), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid_after_busy", 32'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      check("mid_no_valid", 32'(out_valid), 0);
      tick();
    end
    req_data  = 32'h0102_0304;
    req_valid = 4'hF;
    #1;
    check("mid_next_ch0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("sb_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/abs_arbiter.md
ABS_ARBITER -- requirements
Module: abs_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of requesting channels (2..8).
REQ-002 Parameter W, default 8, sample width in bits; samples are signed two's complement.
REQ-003 Parameter THRESH, default 8'd100, unsigned magnitude above which the alarm flag is raised.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 req_valid  input  N_CH  per-channel sample valid.
REQ-007 req_data  input  N_CH*W  packed samples; channel i occupies bits [i*W +: W].
REQ-008 req_ready  output  N_CH  one-hot grant/accept strobe; at most one bit high per cycle.
REQ-009 out_valid  output  1  result available.
REQ-010 out_data  output  W  unsigned magnitude |sample|.
REQ-011 out_ch  output  clog2(N_CH)  channel index of the current result.
REQ-012 out_alarm  output  1  high when out_data > THRESH; qualified by out_valid.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have three states: IDLE, CALC and HOLD.
REQ-016 IDLE: if any req_valid bit is set, the arbiter SHALL assert req_ready for exactly one chosen channel (combinational), latch that channel's sample and index, and go to CALC; otherwise it SHALL remain in IDLE.
REQ-017 A transfer SHALL occur only when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-018 Arbitration SHALL be round-robin: search starts at last_grant+1 and wraps modulo N_CH; last_grant SHALL update only on a completed transfer.
REQ-019 CALC: the latched operand SHALL pass through the absolute-value datapath; the result and alarm SHALL be registered, and the FSM SHALL go to HOLD.
REQ-020 HOLD: out_valid SHALL be high; out_data, out_ch and out_alarm SHALL stay stable until out_ready is high, and the FSM SHALL then go to IDLE on the next edge.
REQ-021 Latency: a sample accepted in cycle t SHALL appear with out_valid high in cycle t+2; peak throughput is one sample per 3 cycles.
REQ-022 req_ready SHALL be all-zero in CALC and HOLD; requests arriving then SHALL wait, and none SHALL be dropped.
REQ-023 Magnitude SHALL be the W-bit two's-complement negation for negative inputs and pass-through otherwise; -2^(W-1) SHALL yield 2^(W-1) read as unsigned (0x80 for W=8).
REQ-024 out_alarm SHALL use a strict unsigned comparison; a magnitude equal to THRESH SHALL NOT raise the alarm.
REQ-025 If out_ready is high on the first cycle of HOLD, the FSM SHALL leave HOLD after exactly one out_valid cycle.
REQ-026 A req_valid deasserted while the FSM is not in IDLE SHALL have no effect; the arbiter does not track or store requests.

Reset
REQ-027 When rst_n is low at a clock edge: state = IDLE, last_grant = N_CH-1 (so channel 0 has first priority), and the operand, result, out_ch and out_alarm registers are cleared.
REQ-028 While reset is asserted: out_valid = 0, req_ready = 0 and busy = 0.
REQ-029 A reset asserted in CALC or HOLD SHALL discard the in-flight result without asserting out_valid.

Structure
REQ-030 State encodings (IDLE, CALC, HOLD) and the default THRESH constant SHALL live in the shared package abs_pkg.
REQ-031 The negation SHALL be done by one instance of the existing absoluteCalculator sub-module (W = 8); no other arithmetic sub-module SHALL be used.
REQ-032 The round-robin selection SHALL be a combinational function inside abs_arbiter, not a separate module.

Verification
REQ-033 Single request: ch2 sends 8'hF6 (-10) with out_ready=1 -> req_ready[2] at t, then out_valid at t+2 with out_data=10, out_ch=2, out_alarm=0.
REQ-034 Round-robin: all four req_valid held high for 12 cycles -> grants in order ch0, ch1, ch2, ch3, each 3 cycles apart.
REQ-035 Boundary magnitudes: inputs 8'h80, 8'h7F, 8'h00 and 8'h9C (-100) -> out_data 0x80 with alarm 1, 0x7F with alarm 1, 0x00 with alarm 0, and 100 with alarm 0.
REQ-036 Backpressure: out_ready held low for 5 cycles in HOLD -> out_valid and out_data stay stable and req_ready stays 0; accept on out_ready=1, then IDLE.
REQ-037 Reset mid-operation: rst_n low during CALC -> next cycle busy=0, out_valid never asserted, and the next grant goes to ch0.
